// File: rtl/entropy_src_enable_seq_pkg.sv
// Shared types for the entropy_src enable sequencer.
// State codes are pairwise Hamming distance >= 3, so a single upset never yields another valid state.
package entropy_src_pkg;

  localparam int EnableSeqStateWidth = 6;

  typedef enum logic [EnableSeqStateWidth-1:0] {
    EsOff     = 6'b000111,
    EsOn      = 6'b011001,
    EsDrain   = 6'b101010,
    EsShaWait = 6'b110100,
    EsSettle  = 6'b111111
  } enable_seq_state_e;

endpackage

// File: rtl/caliptra_prim_sparse_fsm_flop.sv
// State register for sparsely encoded FSMs; the raw vector is kept so corrupted codes stay visible.
module caliptra_prim_sparse_fsm_flop #(
  parameter int               Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] state_i,
  output logic [Width-1:0] state_o
);

  logic [Width-1:0] state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ResetValue;
    end else begin
      state_q <= state_i;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/entropy_src_enable_seq.sv
// Disable/re-enable sequencer: keeps the datapath enabled while pipeline FIFOs drain,
// then waits out any in-flight SHA3 block before allowing a fresh enable.
module entropy_src_enable_seq
  import entropy_src_pkg::*;
#(
  parameter int                  NumFifos         = 4,
  parameter int                  MaxFifoWait      = 4,
  parameter int                  ShaTimeout       = 256,
  parameter logic [NumFifos-1:0] BypassIgnoreMask = NumFifos'(4'b0011)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic [NumFifos-1:0] fifo_not_empty_i,
  input  logic                bypass_mode_i,
  input  logic                cs_aes_halt_req_i,
  input  logic                sha3_block_processed_i,
  output logic                enable_o,
  output logic                busy_o,
  output logic                drain_truncated_o,
  output logic                sha_timeout_o,
  output logic                fsm_err_o
);

  localparam int DrainW = $clog2(MaxFifoWait + 1);
  localparam int ShaW   = (ShaTimeout > 0) ? $clog2(ShaTimeout + 1) : 1;
  localparam logic [DrainW-1:0] DrainLoad = DrainW'(MaxFifoWait - 1);
  localparam logic [ShaW-1:0]   ShaLoad   = (ShaTimeout > 0) ? ShaW'(ShaTimeout - 1) : '0;

  if (NumFifos < 1) begin : gen_bad_num_fifos
    $error("NumFifos must be at least 1");
  end
  if (MaxFifoWait < 1) begin : gen_bad_max_fifo_wait
    $error("MaxFifoWait must be at least 1");
  end
  if ($bits(BypassIgnoreMask) != NumFifos) begin : gen_bad_mask_width
    $error("BypassIgnoreMask width must equal NumFifos");
  end

  enable_seq_state_e             state_d, state_q;
  logic [EnableSeqStateWidth-1:0] state_raw;
  logic [DrainW-1:0]             drain_cnt_d, drain_cnt_q;
  logic [ShaW-1:0]               sha_cnt_d, sha_cnt_q;
  logic                          sha_pend_d, sha_pend_q;
  logic                          sha3_done_q;
  logic                          drain_truncated_d, drain_truncated_q;
  logic                          sha_timeout_d, sha_timeout_q;
  logic                          pending;
  logic                          fsm_err;

  caliptra_prim_sparse_fsm_flop #(
    .Width      (EnableSeqStateWidth),
    .ResetValue (EsOff)
  ) u_state_regs (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .state_i (state_d),
    .state_o (state_raw)
  );

  assign state_q = enable_seq_state_e'(state_raw);

  always_comb begin
    pending = |(fifo_not_empty_i & ~(bypass_mode_i ? BypassIgnoreMask : {NumFifos{1'b0}}));

    // A new halt request outranks a same-cycle block-done indication.
    sha_pend_d = sha_pend_q;
    if (cs_aes_halt_req_i && !enable_i) begin
      sha_pend_d = 1'b1;
    end else if (sha3_done_q) begin
      sha_pend_d = 1'b0;
    end

    state_d           = state_q;
    drain_cnt_d       = drain_cnt_q;
    sha_cnt_d         = sha_cnt_q;
    drain_truncated_d = 1'b0;
    sha_timeout_d     = 1'b0;
    fsm_err           = 1'b0;

    case (state_q)
      EsOff: begin
        if (enable_i) state_d = EsOn;
      end
      EsOn: begin
        if (!enable_i) begin
          state_d     = EsDrain;
          drain_cnt_d = DrainLoad;
        end
      end
      EsDrain: begin
        if (!pending || drain_cnt_q == '0) begin
          drain_truncated_d = pending;
          if (sha_pend_q) begin
            state_d   = EsShaWait;
            sha_cnt_d = ShaLoad;
          end else begin
            state_d = EsSettle;
          end
        end else begin
          drain_cnt_d = drain_cnt_q - DrainW'(1);
        end
      end
      EsShaWait: begin
        if (!sha_pend_d) begin
          state_d = EsSettle;
        end else if (ShaTimeout != 0 && sha_cnt_q == '0) begin
          state_d       = EsSettle;
          sha_pend_d    = 1'b0;
          sha_timeout_d = 1'b1;
        end else if (sha_cnt_q != '0) begin
          sha_cnt_d = sha_cnt_q - ShaW'(1);
        end
      end
      EsSettle: begin
        state_d = EsOff;
      end
      default: begin
        // Corrupted encoding is terminal: hold it so the error stays latched until reset.
        fsm_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drain_cnt_q       <= '0;
      sha_cnt_q         <= '0;
      sha_pend_q        <= 1'b0;
      sha3_done_q       <= 1'b0;
      drain_truncated_q <= 1'b0;
      sha_timeout_q     <= 1'b0;
    end else begin
      drain_cnt_q       <= drain_cnt_d;
      sha_cnt_q         <= sha_cnt_d;
      sha_pend_q        <= sha_pend_d;
      sha3_done_q       <= sha3_block_processed_i;
      drain_truncated_q <= drain_truncated_d;
      sha_timeout_q     <= sha_timeout_d;
    end
  end

  assign enable_o          = (state_q == EsOn) || (state_q == EsDrain);
  assign busy_o            = (state_q == EsDrain) || (state_q == EsShaWait) || (state_q == EsSettle);
  assign drain_truncated_o = drain_truncated_q;
  assign sha_timeout_o     = sha_timeout_q;
  assign fsm_err_o         = fsm_err;

endmodule
